// File: rtl/muldiv_iter_pkg.sv
// Shared types and opcode helpers for the iterative multiply/divide unit.
package muldiv_iter_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } muldiv_op_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_acc(input muldiv_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic op_is_sub(input muldiv_op_t op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 1-bit-per-cycle multiply / multiply-accumulate / divide engine
// with flush, busy and a defined divide-by-zero result.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] in_hi,
  input  logic [WIDTH-1:0] in_lo,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_t       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] base_hi_q, base_hi_d;
  logic [WIDTH-1:0] base_lo_q, base_lo_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic             div0_q, div0_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  muldiv_op_t       op_in_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;

  logic [WIDTH:0]   add_x_s, add_y_s;
  logic             add_cin_s;
  logic [WIDTH+1:0] add_sum_s;

  logic [2*WIDTH-1:0] fix_x_s, fix_y_s, fix_sum_s;
  logic               fix_sub_s;
  logic [WIDTH-1:0]   quot_s, rem_s;

  // Operand magnitudes and signs for an incoming request.
  always_comb begin
    op_in_s = muldiv_op_t'(op);
    a_neg_s = op_is_signed(op_in_s) & srca[WIDTH-1];
    b_neg_s = op_is_signed(op_in_s) & srcb[WIDTH-1];
    mag_a_s = a_neg_s ? (~srca + WIDTH'(1)) : srca;
    mag_b_s = b_neg_s ? (~srcb + WIDTH'(1)) : srcb;
  end

  // Shared WIDTH+1 adder: shift-add for multiply, trial subtract for divide.
  // For divide, the carry out (bit WIDTH+1) is set when the trial subtract does not borrow.
  always_comb begin
    add_x_s   = {1'b0, acc_q};
    add_y_s   = {(WIDTH+1){1'b0}};
    add_cin_s = 1'b0;
    if (op_is_div(op_q)) begin
      add_x_s   = {acc_q, low_q[WIDTH-1]};
      add_y_s   = ~{1'b0, a_q};
      add_cin_s = 1'b1;
    end else begin
      add_x_s   = {1'b0, acc_q};
      add_y_s   = low_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}};
      add_cin_s = 1'b0;
    end
    add_sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{(WIDTH+1){1'b0}}, add_cin_s};
  end

  // FIX-stage sign correction and accumulate; MSUB of a negative product becomes an add.
  always_comb begin
    fix_x_s   = op_is_acc(op_q) ? {base_hi_q, base_lo_q} : {(2*WIDTH){1'b0}};
    fix_sub_s = op_is_sub(op_q) ^ neg_q;
    fix_y_s   = fix_sub_s ? ~{acc_q, low_q} : {acc_q, low_q};
    fix_sum_s = fix_x_s + fix_y_s + {{(2*WIDTH-1){1'b0}}, fix_sub_s};
    quot_s    = neg_q ? (~low_q + WIDTH'(1)) : low_q;
    rem_s     = rem_neg_q ? (~acc_q + WIDTH'(1)) : acc_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    acc_d       = acc_q;
    low_d       = low_q;
    base_hi_d   = base_hi_q;
    base_lo_d   = base_lo_q;
    srca_d      = srca_q;
    div0_d      = div0_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          op_d      = op_in_s;
          base_hi_d = in_hi;
          base_lo_d = in_lo;
          srca_d    = srca;
          div0_d    = op_is_div(op_in_s) && (srcb == {WIDTH{1'b0}});
          neg_d     = a_neg_s ^ b_neg_s;
          rem_neg_d = a_neg_s;
          acc_d     = {WIDTH{1'b0}};
          if (op_is_div(op_in_s)) begin
            a_d   = mag_b_s;
            low_d = mag_a_s;
          end else begin
            a_d   = mag_a_s;
            low_d = mag_b_s;
          end
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (op_is_div(op_q)) begin
            if (add_sum_s[WIDTH+1]) begin
              acc_d = add_sum_s[WIDTH-1:0];
              low_d = {low_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = add_x_s[WIDTH-1:0];
              low_d = {low_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = add_sum_s[WIDTH:1];
            low_d = {add_sum_s[0], low_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (div0_q) begin
            hi_d = srca_q;
            lo_d = {WIDTH{1'b1}};
          end else if (op_is_div(op_q)) begin
            hi_d = rem_s;
            lo_d = quot_s;
          end else begin
            hi_d = fix_sum_s[2*WIDTH-1:WIDTH];
            lo_d = fix_sum_s[WIDTH-1:0];
          end
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      op_q        <= OP_MULT;
      a_q         <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      low_q       <= {WIDTH{1'b0}};
      base_hi_q   <= {WIDTH{1'b0}};
      base_lo_q   <= {WIDTH{1'b0}};
      srca_q      <= {WIDTH{1'b0}};
      div0_q      <= 1'b0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      low_q       <= low_d;
      base_hi_q   <= base_hi_d;
      base_lo_q   <= base_lo_d;
      srca_q      <= srca_d;
      div0_q      <= div0_d;
      neg_q       <= neg_d;
      rem_neg_q   <= rem_neg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed table, random ops against a
// plain-arithmetic reference, and flush / ignored-request / reset sequences.
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [2:0]   op;
  logic [W-1:0] srca, srcb, in_hi, in_lo;
  logic         flush;
  logic         busy, out_valid;
  logic [W-1:0] hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op),
    .srca(srca), .srcb(srcb), .in_hi(in_hi), .in_lo(in_lo),
    .flush(flush), .busy(busy), .out_valid(out_valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  vop;
    logic [31:0] a, b, ih, il;
    logic [63:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] ih,
                                            input logic [31:0] il);
    int          ia, ib, q, r;
    longint      ps;
    logic [63:0] prod_s, prod_u, base;
    ia = a;
    ib = b;
    ps = longint'(ia) * longint'(ib);
    prod_s = ps;
    prod_u = {32'd0, a} * {32'd0, b};
    base = {ih, il};
    case (o)
      3'd0: return prod_s;
      3'd1: return prod_u;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      3'd4: return base + prod_s;
      3'd5: return base + prod_u;
      3'd6: return base - prod_s;
      default: return base - prod_u;
    endcase
  endfunction

  // Issue one request in the current (IDLE) cycle and check latency, busy and result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ih, input logic [31:0] il,
                        input string name, input logic [63:0] exp);
    int   lat;
    logic busy_ok;
    op = o; srca = a; srcb = b; in_hi = ih; in_lo = il; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 60) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    check({name, " latency"}, 64'(lat), 64'd34);
    check({name, " busy"}, {63'd0, busy_ok}, 64'd1);
    check({name, " result"}, {hi, lo}, exp);
    tick();
    check({name, " idle"}, {62'd0, busy, out_valid}, 64'd0);
  endtask

  // Run n cycles, reporting whether out_valid was seen and whether hi/lo left exp.
  task automatic watch(input int n, input logic [63:0] exp, output logic ov_seen,
                       output logic moved);
    ov_seen = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (out_valid) ov_seen = 1'b1;
      if ({hi, lo} !== exp) moved = 1'b1;
      tick();
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        ov, mv;
    logic [2:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    int          lat;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'd0, 32'd0,          64'hFFFFFFFF_FFFFFFEB, "mult_m3x7"};
    vecs[1]  = '{3'd3, 32'd100,      32'd7,        32'd0, 32'd0,          64'h00000002_0000000E, "divu_100_7"};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,          64'hFFFFFFFF_FFFFFFFD, "div_m7_2"};
    vecs[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,          64'h00000000_80000000, "div_min_m1"};
    vecs[4]  = '{3'd3, 32'd5,        32'd0,        32'd0, 32'd0,          64'h00000005_FFFFFFFF, "divu_by0"};
    vecs[5]  = '{3'd5, 32'd1,        32'd1,        32'd0, 32'hFFFFFFFF,   64'h00000001_00000000, "maddu_carry"};
    vecs[6]  = '{3'd6, 32'd2,        32'd3,        32'd0, 32'd0,          64'hFFFFFFFF_FFFFFFFA, "msub_2x3"};
    vecs[7]  = '{3'd2, 32'hFFFFFFFB, 32'd0,        32'd0, 32'd0,          64'hFFFFFFFB_FFFFFFFF, "div_m5_by0"};
    vecs[8]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,          64'hFFFFFFFE_00000001, "multu_max"};
    vecs[9]  = '{3'd4, 32'hFFFFFFFF, 32'd5,        32'd0, 32'd10,         64'h00000000_00000005, "madd_m1x5"};
    vecs[10] = '{3'd7, 32'd4,        32'd4,        32'd1, 32'd0,          64'h00000000_FFFFFFF0, "msubu_borrow"};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = 3'd0;
    srca = '0; srcb = '0; in_hi = '0; in_lo = '0;
    #1;
    check("reset outputs", {30'd0, busy, out_valid, hi, lo}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].vop, vecs[i].a, vecs[i].b, vecs[i].ih, vecs[i].il, vecs[i].name, vecs[i].exp);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = rand_operand(); rb = rand_operand();
      rh = $urandom; rl = $urandom;
      run_op(ro, ra, rb, rh, rl, $sformatf("rand%0d_op%0d", i, ro), ref_model(ro, ra, rb, rh, rl));
    end

    // Known prior result, then MULTU flushed in cycle 10.
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, 32'd0, 32'd0, "prior", 64'hFFFFFFFF_FFFFFFEB);
    op = 3'd1; srca = 32'h12345678; srcb = 32'h9ABCDEF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", {63'd0, busy}, 64'd0);
    watch(40, 64'hFFFFFFFF_FFFFFFEB, ov, mv);
    check("flush no out_valid", {63'd0, ov}, 64'd0);
    check("flush hold hi/lo", {63'd0, mv}, 64'd0);

    // in_valid together with flush in IDLE is not accepted.
    op = 3'd1; srca = 32'd3; srcb = 32'd3; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush+valid busy", {63'd0, busy}, 64'd0);
    watch(40, 64'hFFFFFFFF_FFFFFFEB, ov, mv);
    check("flush+valid no out_valid", {63'd0, ov}, 64'd0);
    check("flush+valid hold hi/lo", {63'd0, mv}, 64'd0);

    // in_valid pulsed in cycle 5 of a DIV must be ignored.
    op = 3'd2; srca = 32'hFFFFFFF9; srcb = 32'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      if (lat == 5) begin
        op = 3'd3; srca = 32'd100; srcb = 32'd7; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("ignore latency", 64'(lat), 64'd34);
    check("ignore result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    tick();
    watch(40, 64'hFFFFFFFF_FFFFFFFD, ov, mv);
    check("ignore no second result", {63'd0, ov}, 64'd0);

    // Reset asserted in cycle 20 clears everything immediately.
    op = 3'd0; srca = 32'd9; srcb = 32'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    #1;
    check("async reset outputs", {30'd0, busy, out_valid, hi, lo}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    watch(40, 64'd0, ov, mv);
    check("post reset no out_valid", {63'd0, ov}, 64'd0);
    check("post reset hi/lo zero", {63'd0, mv}, 64'd0);
    check("post reset busy", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage, successor to the fixed-width multiplier/divider pair. One shared 1-bit-per-cycle engine serves signed/unsigned multiply, multiply-accumulate/subtract, and divide. It adds a pipeline flush, a `busy` indication and a fully defined divide-by-zero result. Results feed the HI/LO write path exactly as the current `mul_hi`/`div_hi` outputs do.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request; accepted only in IDLE with `flush`=0.
- `op`  in  3  `muldiv_op_t`: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU (bit0=1 means unsigned).
- `srca`  in  WIDTH  rs operand; dividend for DIV ops.
- `srcb`  in  WIDTH  rt operand; divisor for DIV ops.
- `in_hi`, `in_lo`  in  WIDTH each  accumulator base for MADD*/MSUB*.
- `flush`  in  1  abort the current operation.
- `busy`  out  1  state != IDLE.
- `out_valid`  out  1  one-cycle pulse; `hi`/`lo` hold a new result.
- `hi`, `lo`  out  WIDTH each  result; remainder/quotient for divides.

## Operation
- FSM states: IDLE → CALC → FIX → DONE → IDLE.
- IDLE
  - When `in_valid`=1 and `flush`=0, latch `op`, `srca`, `srcb`, `in_hi`, `in_lo`.
  - Signed ops convert operands to magnitudes and record the result signs.
  - Load counter = WIDTH and go to CALC.
- CALC, multiply: one shift-add step per cycle.
- CALC, divide: one restoring step per cycle on magnitudes.
- CALC exits to FIX when the counter reaches 0.
- FIX
  - Multiply: negate the 2·WIDTH product if the operand signs differed.
  - Divide: negate the quotient if the signs differed; the remainder takes the dividend's sign.
  - MADD*: {hi,lo} = {in_hi,in_lo} + product.
  - MSUB*: {hi,lo} = {in_hi,in_lo} − product.
  - All 2·WIDTH arithmetic wraps modulo 2^(2·WIDTH).
  - Register `hi`/`lo`, then go to DONE.
- DONE: `out_valid`=1 for one cycle, then IDLE.
- Divide by zero (signed or unsigned): `lo` = all ones, `hi` = `srca`, with normal latency.
- Signed MIN / −1: `lo` = MIN, `hi` = 0, which falls out of the magnitude path.
- `flush`
  - In any state, go to IDLE on the next edge.
  - No `out_valid`; `hi`/`lo` keep their previous values.
  - Wins over a simultaneous `in_valid`.
- `in_valid` outside IDLE is ignored. The stall logic must hold the instruction while `busy`=1.

## Timing
- Reset: state IDLE, `busy`=0, `out_valid`=0, `hi`=`lo`=0, counter 0, operand registers 0.
- Cycle 0 is the accept cycle; the request is captured at its closing edge.
- Cycles 1..WIDTH: CALC, `busy`=1.
- Cycle WIDTH+1: FIX.
- Cycle WIDTH+2: DONE, `out_valid`=1, `busy`=1, results valid.
- Latency is WIDTH+2 cycles; cycle 34 for WIDTH=32.
- Next accept is at cycle WIDTH+3 at the earliest; throughput is one operation per WIDTH+3 cycles.
- `hi`/`lo` change only at the FIX→DONE edge and stay stable until the next FIX.
- Reset asserted mid-operation takes effect immediately and asynchronously; no `out_valid` follows.

## Structure
- `muldiv_op_t` (3-bit enum, encodings 000..111 in the order listed) goes in `cpu_defs.svh`.
- The FSM state enum is local to the module.
- No sub-module: one FSM, one WIDTH+1-bit adder/subtractor shared by the multiply and divide steps, and one 2·WIDTH-bit adder for FIX.

## Test plan
All cases use WIDTH=32.
- MULT srca=−3, srcb=7 → `hi`=FFFFFFFF, `lo`=FFFFFFEB. `out_valid` pulses in cycle 34 only; `busy` is high in cycles 1–34.
- DIVU 100/7 → `lo`=14, `hi`=2. DIV −7/2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF.
- DIV 80000000/FFFFFFFF → `lo`=80000000, `hi`=0. DIVU 5/0 → `lo`=FFFFFFFF, `hi`=5.
- MADDU with in_hi=0, in_lo=FFFFFFFF, 1·1 → `hi`=1, `lo`=0. MSUB with in_hi=in_lo=0, 2·3 → `hi`=FFFFFFFF, `lo`=FFFFFFFA.
- Start MULTU, assert `flush` in cycle 10 → `busy`=0 in cycle 11, no `out_valid`, `hi`/`lo` keep the prior result. `in_valid` with `flush` in the same IDLE cycle → not accepted.
- `in_valid` pulsed in cycle 5 of a DIV → ignored, first result unaffected. Assert `rst` in cycle 20 → outputs are 0 immediately and stay 0.
